branch_target_table: RTL

- Runtime-programmable branch-target lookup table for the single-cycle core; replaces the hard-coded per-program target table.
- Maps a narrow branch pointer (Addr) to a full PC target, combinationally, for the fetch stage.
- Entries are written individually by a debug/host write port, or bulk-loaded from a boot stream by an internal load FSM.
- Entries can be absolute or PC-relative when the optional feature is compiled in.

---
 rtl/branch_target_table.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/branch_target_table.sv
// ---------------------------------------------------------------------------
// branch_target_table
//   Runtime-programmable branch-target lookup table. A narrow branch pointer
//   (Addr) is mapped combinationally to a full PC target for the fetch stage.
//   Entries are written one at a time via the WrEn port or bulk-loaded from a
//   boot stream by the internal IDLE/LOAD/DONE load FSM.
//
//   Optional feature macro: BRANCH_TARGET_TABLE_REL_EN
//     defined   : hits on rel=1 entries return PC + signed value (mod 2**TARGET_W)
//     undefined : rel bits are stored but ignored, every hit is absolute
//
// Ports
//   Clk       in   rising-edge clock
//   Reset     in   synchronous active-low reset
//   Addr      in   lookup pointer
//   PC        in   current PC (relative entries only)
//   Target    out  looked-up target (combinational)
//   Hit       out  valid entry selected and table not busy
//   WrEn/WrAddr/WrData/WrRel  in  single-entry write port (IDLE only)
//   LdStart   in   pulse starting a bulk load
//   LdValid   in   boot-stream word valid
//   LdData    in   boot word {rel, value}
//   LdReady   out  FSM accepts a word this cycle (registered)
//   LdDone    out  one-cycle load-complete pulse (registered)
//   Busy      out  load in flight (registered)
// ---------------------------------------------------------------------------
module branch_target_table #(
    parameter int ADDR_W         = 5,
    parameter int TARGET_W       = 10,
    parameter int DEFAULT_TARGET = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [TARGET_W-1:0] PC,
    output logic [TARGET_W-1:0] Target,
    output logic                Hit,
    input  logic                WrEn,
    input  logic [ADDR_W-1:0]   WrAddr,
    input  logic [TARGET_W-1:0] WrData,
    input  logic                WrRel,
    input  logic                LdStart,
    input  logic                LdValid,
    input  logic [TARGET_W:0]   LdData,
    output logic                LdReady,
    output logic                LdDone,
    output logic                Busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      rel_q, rel_d;
    logic [TARGET_W-1:0]   value_q [DEPTH];
    logic [TARGET_W-1:0]   value_d [DEPTH];
    logic                  ld_ready_q, ld_ready_d;
    logic                  ld_done_q, ld_done_d;
    logic                  busy_q, busy_d;

    // Next-state, table update and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        rel_d   = rel_q;
        value_d = value_q;
        case (state_q)
            ST_IDLE: begin
                // LdStart has priority; a coincident single write is dropped.
                if (LdStart) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    valid_d = '0;
                end else if (WrEn) begin
                    valid_d[WrAddr] = 1'b1;
                    rel_d[WrAddr]   = WrRel;
                    value_d[WrAddr] = WrData;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (LdValid) begin
                    valid_d[ptr_q] = 1'b1;
                    rel_d[ptr_q]   = LdData[TARGET_W];
                    value_d[ptr_q] = LdData[TARGET_W-1:0];
                    // Leave LOAD on the last index so the pointer never wraps.
                    if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered, so decode them from the next state.
        ld_ready_d = (state_d == ST_LOAD);
        ld_done_d  = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    // Control state and valid bits, with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            valid_q    <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            ld_ready_q <= ld_ready_d;
            ld_done_q  <= ld_done_d;
            busy_q     <= busy_d;
        end
    end

    // Entry payload storage; contents are don't-care while the valid bit is clear.
    always_ff @(posedge Clk) begin
        rel_q   <= rel_d;
        value_q <= value_d;
    end

    // Combinational lookup from the registered table (old data on collision).
    always_comb begin
        Hit    = 1'b0;
        Target = TARGET_W'(DEFAULT_TARGET);
        if (!busy_q && valid_q[Addr]) begin
            Hit = 1'b1;
`ifdef BRANCH_TARGET_TABLE_REL_EN
            // Signed offset add; truncation gives the modulo wrap.
            if (rel_q[Addr]) begin
                Target = PC + value_q[Addr];
            end else begin
                Target = value_q[Addr];
            end
`else
            Target = value_q[Addr];
`endif
        end else begin
            Hit    = 1'b0;
            Target = TARGET_W'(DEFAULT_TARGET);
        end
    end

`ifndef BRANCH_TARGET_TABLE_REL_EN
    // PC and rel bits have no effect on the lookup in the absolute-only build.
    logic unused_rel_s;
    assign unused_rel_s = ^{PC, rel_q};
`endif

    assign LdReady = ld_ready_q;
    assign LdDone  = ld_done_q;
    assign Busy    = busy_q;

endmodule
